// File: rtl/reg_check_monitor.sv
// Table-driven end-of-test register checker: waits (fixed delay or halt/timeout), then probes each enabled entry.
// Latency 1 + WAIT_CYCLES + 2*enabled + disabled in fixed mode; config writes and starts are dropped while busy.
`timescale 1ns/1ps
module reg_check_monitor #(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int NUM_CHECKS  = 4,
  parameter int WAIT_MODE   = 0,
  parameter int WAIT_CYCLES = 100,
  localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int CW = $clog2(NUM_CHECKS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic              cfg_en,
  input  logic [REG_AW-1:0] cfg_reg,
  input  logic [XLEN-1:0]   cfg_val,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [XLEN-1:0]   rf_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [CW-1:0]     fail_count,
  output logic [IW-1:0]     fail_idx,
  output logic [XLEN-1:0]   fail_actual
);

  localparam int              CNTW      = $clog2(WAIT_CYCLES + 1);
  localparam logic [IW:0]     NUM_ENT   = (IW + 1)'(NUM_CHECKS);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(NUM_CHECKS - 1);
  localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(WAIT_CYCLES);
  localparam bit              HALT_MODE = (WAIT_MODE == 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_CMP, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timed_out_q, timed_out_d;
  logic [CW-1:0]     fail_count_q, fail_count_d;
  logic [IW-1:0]     fail_idx_q, fail_idx_d;
  logic [XLEN-1:0]   fail_actual_q, fail_actual_d;
  logic [REG_AW-1:0] rf_raddr_q, rf_raddr_d;

  logic              tbl_en_q  [NUM_CHECKS];
  logic              tbl_en_d  [NUM_CHECKS];
  logic [REG_AW-1:0] tbl_reg_q [NUM_CHECKS];
  logic [REG_AW-1:0] tbl_reg_d [NUM_CHECKS];
  logic [XLEN-1:0]   tbl_val_q [NUM_CHECKS];
  logic [XLEN-1:0]   tbl_val_d [NUM_CHECKS];

  logic wait_done, cur_en, last_idx;

  assign wait_done = (cnt_q == CNT_MAX);
  assign cur_en    = tbl_en_q[idx_q];
  assign last_idx  = (idx_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Halt has priority over the timeout limit when both land in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = start ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (HALT_MODE) begin
          if (halt)           state_d = S_ADDR;
          else if (wait_done) state_d = S_DONE;
        end else if (wait_done) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cur_en)        state_d = S_CMP;
        else if (last_idx) state_d = S_DONE;
      end
      S_CMP:   state_d = last_idx ? S_DONE : S_ADDR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q == S_WAIT) || (state_q == S_ADDR) || (state_q == S_CMP);
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    done_d        = done_q;
    pass_d        = pass_q;
    timed_out_d   = timed_out_q;
    fail_count_d  = fail_count_q;
    fail_idx_d    = fail_idx_q;
    fail_actual_d = fail_actual_q;
    rf_raddr_d    = rf_raddr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d         = '0;
          idx_d         = '0;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          timed_out_d   = 1'b0;
          fail_count_d  = '0;
          fail_idx_d    = '0;
          fail_actual_d = '0;
        end
      end
      S_WAIT: begin
        idx_d = '0;
        if (!wait_done) cnt_d = cnt_q + CNTW'(1);
        if (HALT_MODE && !halt && wait_done) begin
          timed_out_d = 1'b1;
          done_d      = 1'b1;
          pass_d      = 1'b0;
        end
      end
      S_ADDR: begin
        if (cur_en) begin
          rf_raddr_d = tbl_reg_q[idx_q];
        end else if (last_idx) begin
          done_d = 1'b1;
          pass_d = (fail_count_q == '0) && !timed_out_q;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_CMP: begin
        if (rf_rdata != tbl_val_q[idx_q]) begin
          fail_count_d = fail_count_q + CW'(1);
          if (fail_count_q == '0) begin
            fail_idx_d    = idx_q;
            fail_actual_d = rf_rdata;
          end
        end
        if (last_idx) begin
          done_d = 1'b1;
          pass_d = (fail_count_d == '0) && !timed_out_q;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    tbl_en_d  = tbl_en_q;
    tbl_reg_d = tbl_reg_q;
    tbl_val_d = tbl_val_q;
    if (cfg_we && !busy && ({1'b0, cfg_idx} < NUM_ENT)) begin
      tbl_en_d[cfg_idx]  = cfg_en;
      tbl_reg_d[cfg_idx] = cfg_reg;
      tbl_val_d[cfg_idx] = cfg_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      fail_count_q  <= '0;
      fail_idx_q    <= '0;
      fail_actual_q <= '0;
      rf_raddr_q    <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tbl_en_q[i]  <= 1'b0;
        tbl_reg_q[i] <= '0;
        tbl_val_q[i] <= '0;
      end
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timed_out_q   <= timed_out_d;
      fail_count_q  <= fail_count_d;
      fail_idx_q    <= fail_idx_d;
      fail_actual_q <= fail_actual_d;
      rf_raddr_q    <= rf_raddr_d;
      tbl_en_q      <= tbl_en_d;
      tbl_reg_q     <= tbl_reg_d;
      tbl_val_q     <= tbl_val_d;
    end
  end

  // The probe address is presented combinationally in ADDR so a one-cycle read returns data in CMP.
  assign rf_raddr    = rf_raddr_d;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timed_out   = timed_out_q;
  assign fail_count  = fail_count_q;
  assign fail_idx    = fail_idx_q;
  assign fail_actual = fail_actual_q;

endmodule

// File: tb/tb_reg_check_monitor.sv
// Bench for reg_check_monitor: one fixed-delay instance (50 cycles) and one halt/timeout instance (100 cycles),
// each probing a registered register-file model; results compared against a table-level reference.
`timescale 1ns/1ps
module tb_reg_check_monitor;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset [2];
  logic        start [2];
  logic        halt [2];
  logic        cfg_we [2];
  logic [1:0]  cfg_idx;
  logic        cfg_en;
  logic [4:0]  cfg_reg;
  logic [31:0] cfg_val;
  logic [4:0]  rf_raddr [2];
  logic [31:0] rf_rdata [2];
  logic        busy [2];
  logic        done [2];
  logic        pass [2];
  logic        timed_out [2];
  logic [2:0]  fail_count [2];
  logic [1:0]  fail_idx [2];
  logic [31:0] fail_actual [2];

  reg_check_monitor #(.XLEN(32), .REG_AW(5), .NUM_CHECKS(N), .WAIT_MODE(0), .WAIT_CYCLES(50)) u_dut0 (
    .clk(clk), .reset(reset[0]), .start(start[0]), .halt(halt[0]),
    .cfg_we(cfg_we[0]), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_reg(cfg_reg), .cfg_val(cfg_val),
    .rf_raddr(rf_raddr[0]), .rf_rdata(rf_rdata[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .timed_out(timed_out[0]),
    .fail_count(fail_count[0]), .fail_idx(fail_idx[0]), .fail_actual(fail_actual[0])
  );

  reg_check_monitor #(.XLEN(32), .REG_AW(5), .NUM_CHECKS(N), .WAIT_MODE(1), .WAIT_CYCLES(100)) u_dut1 (
    .clk(clk), .reset(reset[1]), .start(start[1]), .halt(halt[1]),
    .cfg_we(cfg_we[1]), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_reg(cfg_reg), .cfg_val(cfg_val),
    .rf_raddr(rf_raddr[1]), .rf_rdata(rf_rdata[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .timed_out(timed_out[1]),
    .fail_count(fail_count[1]), .fail_idx(fail_idx[1]), .fail_actual(fail_actual[1])
  );

  // Register-file probe: data for an address appears one cycle after it is presented.
  logic [31:0] rf_mem [2][32];
  always @(posedge clk) begin
    rf_rdata[0] <= rf_mem[0][rf_raddr[0]];
    rf_rdata[1] <= rf_mem[1][rf_raddr[1]];
  end

  bit          m_en  [2][N];
  logic [4:0]  m_reg [2][N];
  logic [31:0] m_val [2][N];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (failure #%0d)", tag, obs, exp, n_fail);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int d, input int idx, input bit en, input logic [4:0] r,
                           input logic [31:0] v);
    cfg_idx   = 2'(idx);
    cfg_en    = en;
    cfg_reg   = r;
    cfg_val   = v;
    cfg_we[d] = 1'b1;
    tick();
    cfg_we[d] = 1'b0;
    m_en[d][idx]  = en;
    m_reg[d][idx] = r;
    m_val[d][idx] = v;
  endtask

  task automatic clear_model(input int d);
    for (int i = 0; i < N; i++) begin
      m_en[d][i]  = 1'b0;
      m_reg[d][i] = '0;
      m_val[d][i] = '0;
    end
  endtask

  task automatic check_zero(input int d, input string tag);
    check({tag, ".raddr"}, rf_raddr[d], 0);
    check({tag, ".busy"}, busy[d], 0);
    check({tag, ".done"}, done[d], 0);
    check({tag, ".pass"}, pass[d], 0);
    check({tag, ".timed_out"}, timed_out[d], 0);
    check({tag, ".fail_count"}, fail_count[d], 0);
    check({tag, ".fail_idx"}, fail_idx[d], 0);
    check({tag, ".fail_actual"}, fail_actual[d], 0);
  endtask

  // Reference: walk the table in order, then derive timing from how the wait phase ends.
  task automatic model(input int d, input int halt_at, output int lat, output bit to, output int fc,
                       output int fidx, output logic [31:0] fact, output bit ps);
    int w, n_en, n_dis;
    w = (d == 0) ? 50 : 100;
    n_en = 0; n_dis = 0; fc = 0; fidx = 0; fact = '0; to = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_en[d][i]) begin
        n_en++;
        if (rf_mem[d][m_reg[d][i]] != m_val[d][i]) begin
          if (fc == 0) begin
            fidx = i;
            fact = rf_mem[d][m_reg[d][i]];
          end
          fc++;
        end
      end else begin
        n_dis++;
      end
    end
    if (d == 1 && (halt_at < 0 || halt_at > w)) begin
      to = 1'b1; lat = w + 1; fc = 0; fidx = 0; fact = '0;
    end else begin
      lat = ((d == 1) ? halt_at + 1 : w + 1) + 2 * n_en + n_dis;
    end
    ps = (fc == 0) && !to;
  endtask

  task automatic run_and_check(input int d, input int halt_at, input bit guard, input string tag);
    int lat, fc, fidx, c;
    bit to, ps;
    logic [31:0] fact;
    model(d, halt_at, lat, to, fc, fidx, fact, ps);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    check({tag, ".busy_run"}, busy[d], 1);
    c = 0;
    while (done[d] !== 1'b1 && c < 1000) begin
      halt[d] = (c == halt_at);
      if (guard && c == 10) begin
        cfg_idx = 2'd0; cfg_en = 1'b1; cfg_reg = 5'd7; cfg_val = 32'hDEAD; cfg_we[d] = 1'b1;
      end
      if (guard && c == 20) start[d] = 1'b1;
      tick();
      c++;
      halt[d] = 1'b0; cfg_we[d] = 1'b0; start[d] = 1'b0;
    end
    check({tag, ".latency"}, c, lat);
    check({tag, ".done"}, done[d], 1);
    check({tag, ".busy"}, busy[d], 0);
    check({tag, ".pass"}, pass[d], ps);
    check({tag, ".timed_out"}, timed_out[d], to);
    check({tag, ".fail_count"}, fail_count[d], fc);
    check({tag, ".fail_idx"}, fail_idx[d], fidx);
    check({tag, ".fail_actual"}, fail_actual[d], fact);
    tick(); tick();
    check({tag, ".done_held"}, done[d], 1);
    check({tag, ".pass_held"}, pass[d], ps);
  endtask

  task automatic rand_table(input int d);
    logic [4:0] r;
    for (int i = 0; i < N; i++) begin
      r = 5'($urandom_range(0, 31));
      cfg_write(d, i, 1'($urandom_range(0, 1)), r,
                ($urandom_range(0, 1) == 1) ? rf_mem[d][r] : $urandom);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; start[d] = 1'b0; halt[d] = 1'b0; cfg_we[d] = 1'b0;
      for (int r = 0; r < 32; r++) rf_mem[d][r] = '0;
      clear_model(d);
    end
    cfg_idx = '0; cfg_en = 1'b0; cfg_reg = '0; cfg_val = '0;
    tick(); tick();
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    reset[0] = 1'b0; reset[1] = 1'b0;
    tick();

    // Fixed-delay instance.
    rf_mem[0][7] = 32'h51;
    cfg_write(0, 0, 1'b1, 5'd7, 32'h51);
    run_and_check(0, -1, 1'b0, "single");

    rf_mem[0][5] = 32'h10; rf_mem[0][6] = 32'h21; rf_mem[0][7] = 32'h50;
    cfg_write(0, 0, 1'b1, 5'd5, 32'h10);
    cfg_write(0, 1, 1'b1, 5'd6, 32'h20);
    cfg_write(0, 2, 1'b1, 5'd7, 32'h51);
    run_and_check(0, -1, 1'b0, "multi");

    rf_mem[0][7] = 32'h51;
    cfg_write(0, 0, 1'b1, 5'd7, 32'h51);
    cfg_write(0, 1, 1'b0, 5'd0, 32'h0);
    cfg_write(0, 2, 1'b0, 5'd0, 32'h0);
    run_and_check(0, -1, 1'b1, "guard");

    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < 32; r++) rf_mem[0][r] = $urandom;
      rand_table(0);
      run_and_check(0, -1, 1'b0, $sformatf("rand0_%0d", k));
    end

    rf_mem[0][9] = 32'h1234;
    cfg_write(0, 0, 1'b1, 5'd9, 32'h1235);
    for (int i = 1; i < N; i++) cfg_write(0, i, 1'b0, 5'd0, 32'h0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 0; c < 52; c++) tick();
    check("midcmp.raddr", rf_raddr[0], 9);
    check("midcmp.busy", busy[0], 1);
    reset[0] = 1'b1;
    tick();
    reset[0] = 1'b0;
    clear_model(0);
    check_zero(0, "midcmp_reset");
    run_and_check(0, -1, 1'b0, "after_reset");

    // Halt/timeout instance.
    rf_mem[1][3] = 32'hAAAA; rf_mem[1][4] = 32'hBBBB;
    cfg_write(1, 0, 1'b1, 5'd3, 32'hAAAA);
    cfg_write(1, 1, 1'b1, 5'd4, 32'hBBBC);
    run_and_check(1, 20, 1'b0, "halt20");
    cfg_write(1, 1, 1'b1, 5'd4, 32'hBBBB);
    run_and_check(1, 100, 1'b0, "halt100");
    run_and_check(1, -1, 1'b0, "timeout");
    check("timeout.raddr", rf_raddr[1], 4);

    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < 32; r++) rf_mem[1][r] = $urandom;
      rand_table(1);
      run_and_check(1, int'($urandom_range(0, 130)), 1'b0, $sformatf("rand1_%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
